// File: rtl/serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : serial_transmitter
// Purpose  : Byte serialiser, the Tx partner of the serial receiver. Bytes are
//            queued in a small FIFO and sent on a single line as
//            idle-low / one high start bit / 8 data bits LSB first /
//            at least GAP_CYCLES low guard cycles. One bit per SCin cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   SCin      in   1   clock, all state changes on the rising edge
//   Reset     in   1   asynchronous active-high reset
//   PDin      in   8   parallel byte to queue
//   PDvalid   in   1   source requests a write of PDin
//   PDaccept  out  1   FIFO not full; a write happens when PDvalid & PDaccept
//   SDout     out  1   registered serial data line
//   Busy      out  1   a frame (start, data or gap) is in progress
//   Count     out  CW  bytes queued, excluding the byte being shifted
// ============================================================================
module serial_transmitter #(
  parameter int FIFO_DEPTH = 4,  // power of 2, >= 2
  parameter int GAP_CYCLES = 1   // >= 1
) (
  input  logic                            SCin,
  input  logic                            Reset,
  input  logic [7:0]                      PDin,
  input  logic                            PDvalid,
  output logic                            PDaccept,
  output logic                            SDout,
  output logic                            Busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] Count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Byte FIFO
  // --------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Acceptance depends only on registered occupancy: a full FIFO refuses a
  // write even on an edge where the FSM pops.
  assign PDaccept = (Count != FULL_COUNT);
  assign push     = PDvalid & PDaccept;

  // Storage is not reset: a slot is only ever read after it has been written.
  always_ff @(posedge SCin) begin
    if (push) begin
      mem[wr_ptr] <= PDin;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two. The
  // handshake guarantees no overflow and no underflow of Count.
  always_ff @(posedge SCin or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   Count <= Count + CNT_W'(1);
        2'b01:   Count <= Count - CNT_W'(1);
        default: Count <= Count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [7:0]       shreg;
  logic [7:0]       shreg_nxt;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_nxt;
  logic             sd_nxt;
  logic             have_byte;

  // Count is registered, so a byte written on this edge is seen next edge.
  assign have_byte = (Count != '0);
  assign Busy      = (state != IDLE);

  always_ff @(posedge SCin or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      SDout   <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      SDout   <= sd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    sd_nxt      = 1'b0;
    pop         = 1'b0;

    case (state)
      IDLE: begin
        if (have_byte) begin
          pop       = 1'b1;
          shreg_nxt = mem[rd_ptr];
          sd_nxt    = 1'b1;
          state_nxt = START;
        end
      end

      // Start bit is on the line now; put d0 out and begin shifting.
      START: begin
        sd_nxt      = shreg[0];
        shreg_nxt   = {1'b0, shreg[7:1]};
        bit_cnt_nxt = 3'd0;
        state_nxt   = DATA;
      end

      // bit_cnt tracks which data bit is currently on the line; once d7 has
      // had its cycle the line drops for the guard period.
      DATA: begin
        if (bit_cnt == 3'd7) begin
          sd_nxt      = 1'b0;
          gap_cnt_nxt = GAP_LOAD;
          state_nxt   = GAP;
        end else begin
          sd_nxt      = shreg[0];
          shreg_nxt   = {1'b0, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end

      GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end else if (have_byte) begin
          pop       = 1'b1;
          shreg_nxt = mem[rd_ptr];
          sd_nxt    = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_transmitter
// Purpose  : Self-checking bench for serial_transmitter. Two transmitters
//            (GAP_CYCLES 1 and 3) each get their own stimulus process, a
//            reference model of queue occupancy and line timing, and a
//            serial decoder that checks received bytes against a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_transmitter;

  localparam int DEPTH = 4;

  logic SCin  = 1'b0;
  logic Reset = 1'b1;
  logic go_c3 = 1'b0;
  int   top_total = 0;
  int   top_bad   = 0;

  always #5 SCin = ~SCin;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int GAP    = (gi == 0) ? 1 : 3;
    localparam int PERIOD = 9 + GAP;   // edges between consecutive starts

    logic [7:0] pdin    = 8'h00;
    logic       pdvalid = 1'b0;
    logic       pdaccept;
    logic       sdout;
    logic       busy;
    logic [2:0] count;

    serial_transmitter #(
      .FIFO_DEPTH(DEPTH),
      .GAP_CYCLES(GAP)
    ) dut (
      .SCin    (SCin),
      .Reset   (Reset),
      .PDin    (pdin),
      .PDvalid (pdvalid),
      .PDaccept(pdaccept),
      .SDout   (sdout),
      .Busy    (busy),
      .Count   (count)
    );

    // Reference model: fq = bytes accepted but not started, sb = every
    // accepted byte in order (the scoreboard), cur = byte on the line,
    // since = edges since that byte's start edge (1000 = no frame yet).
    logic [7:0] fq[$];
    logic [7:0] sb[$];
    logic [7:0] cur = 8'h00;
    int         since = 1000;
    bit         acc_last = 1'b0;
    bit         done = 1'b0;
    int         total = 0;
    int         bad = 0;

    always @(posedge SCin or posedge Reset) begin
      int n;
      int since_now;
      bit pop_now;
      if (Reset) begin
        fq.delete();
        sb.delete();
        since    = 1000;
        acc_last = 1'b0;
      end else begin
        n         = fq.size();
        since_now = (since >= 1000) ? 1000 : since + 1;
        pop_now   = (n != 0) && (since_now >= PERIOD);
        acc_last  = pdvalid && (n != DEPTH);
        if (pop_now) begin
          cur   = fq.pop_front();
          since = 0;
        end else begin
          since = since_now;
        end
        if (acc_last) begin
          fq.push_back(pdin);
          sb.push_back(pdin);
        end
      end
    end

    // Monitor: line/status checks each cycle plus a serial decoder.
    int         rx_st  = 0;
    int         rx_n   = 0;
    int         rd_idx = 0;
    logic [7:0] rx_b   = 8'h00;

    task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
        bad++;
        $display("FAIL %s [gap=%0d] t=%0t: got %0d, expected %0d",
                 name, GAP, $time, act, exp);
      end
    endtask

    always @(negedge SCin) begin
      int exp_sd;
      int exp_busy;
      exp_sd = 0;
      if (since == 0) exp_sd = 1;
      else if (since <= 8) exp_sd = int'(cur[since-1]);
      exp_busy = (since <= 8 + GAP) ? 1 : 0;
      check("sdout", int'(sdout), exp_sd);
      check("busy", int'(busy), exp_busy);
      check("count", int'(count), fq.size());
      check("pdaccept", int'(pdaccept), (fq.size() != DEPTH) ? 1 : 0);

      if (Reset) begin
        rx_st  = 0;
        rd_idx = 0;
      end else if (rx_st == 0) begin
        if (sdout) begin
          rx_st = 1;
          rx_n  = 0;
        end
      end else begin
        rx_b[rx_n] = sdout;
        rx_n++;
        if (rx_n == 8) begin
          rx_st = 0;
          if (rd_idx >= sb.size()) begin
            check("rx_unexpected_byte", int'(rx_b), -1);
          end else begin
            check("rx_byte", int'(rx_b), int'(sb[rd_idx]));
            rd_idx++;
          end
        end
      end

      if (!Reset && since == PERIOD + 1 && fq.size() == 0)
        check("all_delivered", rd_idx, sb.size());
    end

    // Stimulus. send() is entered right after a falling edge and returns
    // right after the falling edge that follows the accepting rising edge.
    task automatic send(input logic [7:0] b);
      int waited = 0;
      pdin    = b;
      pdvalid = 1'b1;
      do begin
        @(negedge SCin);
        waited++;
        if (waited > 200) begin
          $display("FAIL send_timeout [gap=%0d]: byte %02h not accepted, required acceptance within 200 cycles", GAP, b);
          $fatal(1);
        end
      end while (!acc_last);
      pdvalid = 1'b0;
    endtask

    task automatic wait_idle();
      int k = 0;
      while (!(fq.size() == 0 && since > PERIOD + 1)) begin
        @(negedge SCin);
        k++;
        if (k > 500) begin
          $display("FAIL idle_timeout [gap=%0d]: still busy, required idle within 500 cycles", GAP);
          $fatal(1);
        end
      end
    endtask

    initial begin
      int k;
      @(negedge SCin);
      while (Reset) @(negedge SCin);

      send(8'hA5);
      wait_idle();

      send(8'h01); send(8'h80); send(8'hFF); send(8'h00);
      wait_idle();

      // Fill the FIFO behind a shifting frame, then hold 8'h55 while full.
      for (int i = 0; i < DEPTH + 1; i++) send(8'(i * 37 + 3));
      send(8'h55);
      wait_idle();

      send(8'h0F); send(8'hF0);
      wait_idle();

      // Push on the pop edge with two bytes queued.
      send(8'h11); send(8'h22); send(8'h33);
      k = 0;
      while (since != PERIOD - 1 && k < 100) begin
        @(negedge SCin);
        k++;
      end
      send(8'h44);
      wait_idle();

      for (int i = 0; i < 3 * DEPTH; i++) send(8'($urandom));
      wait_idle();

      for (int i = 0; i < 20; i++) begin
        send(8'($urandom));
        repeat ($urandom_range(0, 14)) @(negedge SCin);
      end
      wait_idle();

      done = 1'b1;
      wait (go_c3);
      send(8'hC3);
    end
  end

  task automatic tcheck(input string name, input int act, input int exp);
    top_total++;
    if (act != exp) begin
      top_bad++;
      $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge SCin);
    #1 Reset = 1'b0;

    k = 0;
    while (!(g_inst[0].done && g_inst[1].done) && k < 20000) begin
      @(negedge SCin);
      k++;
    end
    tcheck("sequences_done", int'(g_inst[0].done && g_inst[1].done), 1);

    if (g_inst[0].done && g_inst[1].done) begin
      go_c3 = 1'b1;
      k = 0;
      while (g_inst[0].since != 4 && k < 100) begin
        @(negedge SCin);
        k++;
      end
      tcheck("c3_reached_d3", g_inst[0].since, 4);

      // Reset in the middle of the low phase, well away from any edge.
      #2 Reset = 1'b1;
      #1;
      tcheck("rst_sdout_g1",    int'(g_inst[0].sdout),    0);
      tcheck("rst_busy_g1",     int'(g_inst[0].busy),     0);
      tcheck("rst_count_g1",    int'(g_inst[0].count),    0);
      tcheck("rst_pdaccept_g1", int'(g_inst[0].pdaccept), 1);
      tcheck("rst_sdout_g3",    int'(g_inst[1].sdout),    0);
      tcheck("rst_busy_g3",     int'(g_inst[1].busy),     0);
      tcheck("rst_count_g3",    int'(g_inst[1].count),    0);
      tcheck("rst_pdaccept_g3", int'(g_inst[1].pdaccept), 1);

      repeat (2) @(negedge SCin);
      #1 Reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge SCin);
        tcheck("post_rst_low_g1", int'(g_inst[0].sdout), 0);
        tcheck("post_rst_low_g3", int'(g_inst[1].sdout), 0);
      end
    end

    $display("test done: total=%0d bad=%0d",
             top_total + g_inst[0].total + g_inst[1].total,
             top_bad + g_inst[0].bad + g_inst[1].bad);
    $finish;
  end

endmodule
`default_nettype wire
